// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between a load/store unit and dmem_ctrl.
//   master: drives req, we, size, unsigned_ld, addr, w_data; observes ready, r_data, fault, busy
//   slave : the controller side (dmem_ctrl)
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic        ready;
  logic [31:0] r_data;
  logic        fault;
  logic        busy;

  modport master (output req, we, size, unsigned_ld, addr, w_data,
                  input  ready, r_data, fault, busy);
  modport slave  (input  req, we, size, unsigned_ld, addr, w_data,
                  output ready, r_data, fault, busy);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller with fixed wait states.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   bus (slave)   : req/we/size/unsigned_ld/addr/w_data in; ready/r_data/fault/busy out
// Parameters: DEPTH_WORDS (32-bit words), WAIT_STATES (0..7), BASE_ADDR (byte address of word 0).
// Optional macro DMEM_FAULT_EN: fault on misaligned or out-of-range accesses.
// Without it only size=11 faults; misaligned addresses are forced aligned and
// out-of-range indices wrap modulo DEPTH_WORDS.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
`ifdef DMEM_FAULT_EN
  localparam logic [31:0] OFF_LIMIT = 32'(4 * DEPTH_WORDS);
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] w_data;
  } mreq_t;

  state_t      state;
  logic [2:0]  cnt;
  mreq_t       lat, in_req, cur;
  logic        ready_q, fault_q, busy_q;
  logic [31:0] r_data_q;

  logic [31:0]                         a_al, off, ld_val;
  logic                                bad, enter_done;
  logic [AW-1:0]                       idx;
  logic [1:0]                          lane;
  logic [NUM_LANES-1:0]                be, lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0]     wd, rd_word;
  logic [VEC_W-1:0]                    rd_lane [NUM_LANES];
  logic [7:0]                          b;
  logic [15:0]                         h;

  assign in_req = {bus.we, bus.size, bus.unsigned_ld, bus.addr, bus.w_data};
  // In IDLE the request is decoded straight off the bus so a zero-wait access
  // can complete on the next edge; otherwise the latched copy is used.
  assign cur = (state == IDLE) ? in_req : lat;

  always_comb begin
    a_al = cur.addr;
    bad  = (cur.size == 2'b11);
`ifndef DMEM_FAULT_EN
    if (cur.size == 2'b01) a_al[0]   = 1'b0;
    if (cur.size == 2'b10) a_al[1:0] = 2'b00;
`endif
    off = a_al - BASE_ADDR;
`ifdef DMEM_FAULT_EN
    if (cur.size == 2'b01 && cur.addr[0])         bad = 1'b1;
    if (cur.size == 2'b10 && cur.addr[1:0] != 0)  bad = 1'b1;
    if (off >= OFF_LIMIT)                         bad = 1'b1;
`endif
    // Truncation gives the wrap modulo DEPTH_WORDS.
    idx  = AW'(off >> 2);
    lane = a_al[1:0];

    be = 4'b1111;
    wd = cur.w_data;
    case (cur.size)
      2'b00: begin be = 4'b0001 << lane; wd = {4{cur.w_data[7:0]}}; end
      2'b01: begin be = lane[1] ? 4'b1100 : 4'b0011; wd = {2{cur.w_data[15:0]}}; end
      default: ;
    endcase

    for (int i = 0; i < NUM_LANES; i++) rd_word[i] = rd_lane[i];
    b = rd_word[lane];
    h = lane[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    ld_val = rd_word;
    case (cur.size)
      2'b00:   ld_val = cur.unsigned_ld ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   ld_val = cur.unsigned_ld ? {16'h0, h} : {{16{h[15]}}, h};
      default: ;
    endcase
  end

  // Store commits on the edge that leaves DONE; a reset on that edge drops it.
  assign lane_we = (state == DONE && cur.we && !bad && !rst) ? be : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [VEC_W-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
      if (lane_we[i]) mem[idx] <= wd[i];
    assign rd_lane[i] = mem[idx];
  end

  assign enter_done = (state == IDLE && bus.req && (WAIT_STATES == 0)) ||
                      (state == WAIT && cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      r_data_q <= '0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      if (state == IDLE && bus.req) lat <= in_req;
      if (enter_done) begin
        state  <= DONE;
        busy_q <= 1'b1;
        if (bad) fault_q <= 1'b1;
        else begin
          ready_q <= 1'b1;
          if (!cur.we) r_data_q <= ld_val;
        end
      end else begin
        case (state)
          IDLE: if (bus.req) begin
            state  <= WAIT;
            cnt    <= CNT_INIT;
            busy_q <= 1'b1;
          end
          WAIT: cnt <= cnt - 3'd1;
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.fault  = fault_q;
  assign bus.busy   = busy_q;
  assign bus.r_data = r_data_q;
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in storage (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 1, extra cycles between request accept and completion (0..7).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  access request; sampled only in IDLE.
REQ-007 we  in  1  1 = store, 0 = load.
REQ-008 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-010 addr  in  32  byte address.
REQ-011 w_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready  out  1  one-cycle pulse; access complete.
REQ-013 r_data  out  32  load result, extended; valid while ready=1, held until next completion.
REQ-014 fault  out  1  one-cycle pulse; access rejected, replaces ready.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, DONE.
REQ-017 IDLE with req=1: latch we, size, unsigned_ld, addr, w_data; go to WAIT if WAIT_STATES>0, else DONE.
REQ-018 WAIT: down-counter loaded with WAIT_STATES-1; go to DONE when counter is 0; req ignored.
REQ-019 DONE: assert ready or fault for exactly one cycle, then return to IDLE; latency req-to-ready = WAIT_STATES+1 cycles.
REQ-020 Back-to-back: req held high is accepted again on the first IDLE cycle after DONE; throughput one access per WAIT_STATES+2 cycles.
REQ-021 Store commits to storage on the DONE cycle only, byte lanes from size and addr[1:0]: byte lane = addr[1:0], half lanes = addr[1]*2 +{0,1}, word = all four.
REQ-022 Load reads the word at DONE, selects lane(s) by addr[1:0]/size, extends per unsigned_ld into r_data.
REQ-023 Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
REQ-024 size=11 treated as fault in all configurations; no storage change; r_data unchanged.
REQ-025 ready and fault never high in the same cycle; busy=0 exactly when state is IDLE.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, counter 0, ready 0, fault 0, busy 0, r_data 32'h0.
REQ-027 rst during WAIT or DONE aborts the access; a pending store is not committed.
REQ-028 Storage contents are not cleared by reset.

Configuration
REQ-029 Macro DMEM_FAULT_EN defined: misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) produces fault in DONE, no store, r_data unchanged.
REQ-030 DMEM_FAULT_EN undefined: fault driven only for size=11; misaligned addresses are forced aligned (half clears addr[0], word clears addr[1:0]); out-of-range index wraps modulo DEPTH_WORDS.

Verification
REQ-031 WAIT_STATES=1: store word 32'hDEADBEEF @0x10, then load word @0x10 -> ready at cycle 2 after each req, r_data=32'hDEADBEEF.
REQ-032 Store byte 8'h80 @0x13 over 32'h11223344, load byte signed @0x13 -> 32'hFFFFFF80; load word @0x10 -> 32'h80223344.
REQ-033 Load half unsigned @0x12 of 32'h80223344 -> 32'h00008022; signed -> 32'hFFFF8022.
REQ-034 DMEM_FAULT_EN on: store word @0x12 -> fault pulse, ready 0, subsequent word load @0x10 unchanged; DMEM_FAULT_EN off: same store writes word 0x10.
REQ-035 rst asserted in WAIT of store 32'h55AA55AA @0x20 -> outputs 0 next cycle, load @0x20 returns prior contents.
REQ-036 WAIT_STATES=0, req held high for 6 cycles with alternating loads -> ready every second cycle, busy toggles 1/0.
